if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the architectural PC register and computes the next fetch address: reset vector, sequential +4, redirect, or stall-hold.
- Drives the synchronous-read BIOS and IMEM address ports.
- Presents the returned instruction word, its PC and a valid flag to decode one cycle after the address was issued. The memory output register acts as the IF/ID boundary.

---
 rtl/if_stage_pkg.sv | 34 +++
 rtl/if_next_pc.sv | 45 ++++
 rtl/if_stage.sv | 125 ++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage: default reset vector,
// bubble encoding, PC width, the address-region nibbles that select the
// instruction source, and a helper that decodes a PC's top nibble into
// that source.
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int unsigned PC_W         = 32'd32;
    localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [3:0]  REGION_BIOS  = 4'h4;
    localparam logic [3:0]  REGION_IMEM  = 4'h1;

    // Where the instruction for a given PC comes from.
    typedef enum logic [1:0] {
        SRC_BIOS = 2'd0,
        SRC_IMEM = 2'd1,
        SRC_NONE = 2'd2
    } src_e;

    // Decode the PC's top nibble into an instruction source.
    function automatic src_e region_decode(input logic [3:0] nib);
        src_e s;
        case (nib)
            REGION_BIOS: s = SRC_BIOS;
            REGION_IMEM: s = SRC_IMEM;
            default:     s = SRC_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// -----------------------------------------------------------------------------
// if_next_pc
// Combinational next-fetch-address priority mux.
// Priority (highest first): reset vector, redirect target (bit 0 cleared,
// bit 1 passed through), hold on stall, hold while the first fetch after
// reset has not yet been issued, sequential +4 with 32-bit wrap.
// Ports:
//   i_rst, i_redirect, i_redirect_addr, i_stall : control inputs
//   i_valid_q, i_pc_q                           : current PC state
//   o_fetch_pc                                  : address to issue this cycle
// -----------------------------------------------------------------------------
module if_next_pc
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            i_rst,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_addr,
    input  logic            i_stall,
    input  logic            i_valid_q,
    input  logic [PC_W-1:0] i_pc_q,
    output logic [PC_W-1:0] o_fetch_pc
);

    logic [PC_W-1:0] w_redirect_aligned;

    // Only halfword alignment is enforced here; a set bit 1 is faulted later.
    assign w_redirect_aligned = i_redirect_addr & ~32'h0000_0001;

    // Select the fetch address by priority.
    always_comb begin
        o_fetch_pc = i_pc_q;
        if (i_rst) begin
            o_fetch_pc = RESET_PC;
        end else if (i_redirect) begin
            o_fetch_pc = w_redirect_aligned;
        end else if (i_stall || !i_valid_q) begin
            o_fetch_pc = i_pc_q;
        end else begin
            o_fetch_pc = i_pc_q + 32'd4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Owns the PC register, issues word addresses to the
// synchronous-read BIOS and IMEM, and presents the returned instruction, its
// PC and a valid flag to decode one cycle later. The memories' output
// registers form the IF/ID boundary, so stalls simply re-issue the held PC.
// Optional build macro: IF_FETCH_CNT_EN adds fetch_cnt_o, a count of
// instructions accepted by decode.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   stall_i, redirect_i,
//   redirect_addr_i                 : hazard hold and EX-stage redirect
//   bios_addr_o / bios_dout_i       : BIOS address / read data (1-cycle)
//   imem_addr_o / imem_dout_i       : IMEM address / read data (1-cycle)
//   fetch_pc_o                      : address issued this cycle
//   inst_o, pc_o, valid_o           : instruction bundle to decode
//   fetch_cnt_o (IF_FETCH_CNT_EN)   : accepted-instruction counter
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned BIOS_AW  = 32'd12,
    parameter int unsigned IMEM_AW  = 32'd14,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_addr_i,
    output logic [BIOS_AW-1:0] bios_addr_o,
    input  logic [31:0]        bios_dout_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_dout_i,
    output logic [PC_W-1:0]    fetch_pc_o,
    output logic [31:0]        inst_o,
    output logic [PC_W-1:0]    pc_o,
`ifdef IF_FETCH_CNT_EN
    output logic [31:0]        fetch_cnt_o,
`endif
    output logic               valid_o
);

    logic [PC_W-1:0] r_pc;
    logic            r_valid;
    logic [PC_W-1:0] w_fetch_pc;
    src_e            w_src;
    logic [31:0]     w_inst;
    logic            w_valid;

    if_next_pc #(
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .i_rst           (rst),
        .i_redirect      (redirect_i),
        .i_redirect_addr (redirect_addr_i),
        .i_stall         (stall_i),
        .i_valid_q       (r_valid),
        .i_pc_q          (r_pc),
        .o_fetch_pc      (w_fetch_pc)
    );

    // PC register: holds the address whose data the memories are returning now.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_fetch_pc;
            r_valid <= 1'b1;
        end
    end

    // Pick the returned word by the region of the PC it belongs to.
    always_comb begin
        w_src   = region_decode(r_pc[31:28]);
        w_inst  = NOP_INST;
        w_valid = 1'b0;
        if (r_valid) begin
            case (w_src)
                SRC_BIOS: begin
                    w_inst  = bios_dout_i;
                    w_valid = 1'b1;
                end
                SRC_IMEM: begin
                    w_inst  = imem_dout_i;
                    w_valid = 1'b1;
                end
                default: begin
                    w_inst  = NOP_INST;
                    w_valid = 1'b0;
                end
            endcase
        end else begin
            w_inst  = NOP_INST;
            w_valid = 1'b0;
        end
    end

    assign fetch_pc_o  = w_fetch_pc;
    assign bios_addr_o = w_fetch_pc[BIOS_AW+1:2];
    assign imem_addr_o = w_fetch_pc[IMEM_AW+1:2];
    assign pc_o        = r_pc;
    assign inst_o      = w_inst;
    assign valid_o     = w_valid;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    // Count instructions decode actually takes: valid and not held or squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_valid && !stall_i && !redirect_i) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end else begin
            r_fetch_cnt <= r_fetch_cnt;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: a directed vector table covering reset
// release, sequential fetch, stall, redirect-over-stall, unmapped region,
// misaligned redirect and reset over stall; a counter sequence when
// IF_FETCH_CNT_EN is defined; then randomized cycles against a reference
// model that tracks "address issued last cycle" and looks words up directly.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic [11:0] bios_addr_o;
    logic [31:0] bios_dout_i;
    logic [13:0] imem_addr_o;
    logic [31:0] imem_dout_i;
    logic [31:0] fetch_pc_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_o;
`endif

    int n_checks = 0;
    int n_err    = 0;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .bios_addr_o     (bios_addr_o),
        .bios_dout_i     (bios_dout_i),
        .imem_addr_o     (imem_addr_o),
        .imem_dout_i     (imem_dout_i),
        .fetch_pc_o      (fetch_pc_o),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
`ifdef IF_FETCH_CNT_EN
        .fetch_cnt_o     (fetch_cnt_o),
`endif
        .valid_o         (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as closed-form patterns.
    function automatic logic [31:0] bios_word(input logic [11:0] idx);
        if (idx == 12'd0) return 32'h0010_0093;
        return 32'hB100_0000 | {20'd0, idx};
    endfunction

    function automatic logic [31:0] imem_word(input logic [13:0] idx);
        return 32'hC100_0000 | {18'd0, idx};
    endfunction

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        bios_dout_i <= bios_word(bios_addr_o);
        imem_dout_i <= imem_word(imem_addr_o);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] raddr;
        logic [31:0] e_fetch;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [31:0] a, input logic [31:0] f,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic v);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = d; x.raddr = a;
        x.e_fetch = f; x.e_pc = p; x.e_inst = i; x.e_valid = v;
        return x;
    endfunction

    task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] a);
        @(negedge clk);
        rst             = r;
        stall_i         = s;
        redirect_i      = d;
        redirect_addr_i = a;
    endtask

    // Reference model state: address issued in the previous cycle, whether a
    // non-reset edge has happened since reset, and accepted-instruction count.
    logic [31:0] m_last;
    logic        m_started;
    logic        m_known;
    logic [31:0] m_cnt;

    vec_t vecs[19];

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = 32'd0;

        //              rst   stall redir raddr          fetch          pc             inst           valid
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0,         32'h4000_0000, 32'h4000_0000, NOP,           1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'd0,         32'h4000_0000, 32'h4000_0000, NOP,           1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_0000, 32'h4000_0000, NOP,           1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_0004, 32'h4000_0000, 32'h0010_0093, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_0008, 32'h4000_0004, 32'hB100_0001, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'h4000_0008, 32'h4000_0008, 32'hB100_0002, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'h4000_0008, 32'h4000_0008, 32'hB100_0002, 1'b1);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'h4000_0008, 32'h4000_0008, 32'hB100_0002, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_000C, 32'h4000_0008, 32'hB100_0002, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_0010, 32'h4000_000C, 32'hB100_0003, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h1000_0021, 32'h1000_0020, 32'h4000_0010, 32'hB100_0004, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h1000_0024, 32'h1000_0020, 32'hC100_0008, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'h2000_0000, 32'h2000_0000, 32'h1000_0024, 32'hC100_0009, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h2000_0004, 32'h2000_0000, NOP,           1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h2000_0008, 32'h2000_0004, NOP,           1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h4000_0102, 32'h4000_0102, 32'h2000_0008, NOP,           1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_0106, 32'h4000_0102, 32'hB100_0040, 1'b1);
        vecs[17] = mk(1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'h4000_0000, 32'h4000_0106, 32'hB100_0041, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'h4000_0000, 32'h4000_0000, NOP,           1'b0);

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].raddr);
            #1;
            chk($sformatf("vec%0d fetch_pc", i), fetch_pc_o, vecs[i].e_fetch);
            chk($sformatf("vec%0d pc", i), pc_o, vecs[i].e_pc);
            chk($sformatf("vec%0d inst", i), inst_o, vecs[i].e_inst);
            chk($sformatf("vec%0d valid", i), {31'd0, valid_o}, {31'd0, vecs[i].e_valid});
        end

`ifdef IF_FETCH_CNT_EN
        // Ten accepted fetches with two stalls and one redirect interleaved.
        begin
            string pat;
            pat = "AASAARAASAAAA";
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            for (int k = 0; k < pat.len(); k++) begin
                case (pat[k])
                    "S":     drive(1'b0, 1'b1, 1'b0, 32'd0);
                    "R":     drive(1'b0, 1'b0, 1'b1, RST_PC);
                    default: drive(1'b0, 1'b0, 1'b0, 32'd0);
                endcase
            end
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            #1;
            chk("fetch_cnt after 10 accepts", fetch_cnt_o, 32'd10);
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            #1;
            chk("fetch_cnt after reset", fetch_cnt_o, 32'd0);
        end
`endif

        // Randomized phase against the reference model.
        m_known = 1'b0; m_started = 1'b0; m_last = 32'd0; m_cnt = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, d, acc, mapped, e_valid;
            logic [31:0] a, e_fetch, e_inst;
            int          sel;
            r   = (i == 0) ? 1'b1 : ($urandom_range(0, 63) == 0);
            s   = ($urandom_range(0, 3) == 0);
            d   = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0:       a = 32'h4000_0000 | $urandom_range(0, 16383);
                1:       a = 32'h1000_0000 | $urandom_range(0, 65535);
                2:       a = $urandom;
                3:       a = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: a = 32'h1000_FFF8;
            endcase
            drive(r, s, d, a);
            #1;

            // What should be issued now.
            if (r)                       e_fetch = RST_PC;
            else if (d)                  e_fetch = {a[31:1], 1'b0};
            else if (s || !m_started)    e_fetch = m_last;
            else                         e_fetch = m_last + 32'd4;

            // What decode should see: the instruction fetched at m_last.
            mapped  = (m_last[31:28] == 4'h4) || (m_last[31:28] == 4'h1);
            e_valid = m_started && mapped;
            if (!e_valid)                    e_inst = NOP;
            else if (m_last[31:28] == 4'h4)  e_inst = bios_word(m_last[13:2]);
            else                             e_inst = imem_word(m_last[15:2]);

            if (m_known) begin
                chk("rnd fetch_pc", fetch_pc_o, e_fetch);
                chk("rnd bios_addr", {20'd0, bios_addr_o}, {20'd0, e_fetch[13:2]});
                chk("rnd imem_addr", {18'd0, imem_addr_o}, {18'd0, e_fetch[15:2]});
                chk("rnd pc", pc_o, m_last);
                chk("rnd inst", inst_o, e_inst);
                chk("rnd valid", {31'd0, valid_o}, {31'd0, e_valid});
`ifdef IF_FETCH_CNT_EN
                chk("rnd fetch_cnt", fetch_cnt_o, m_cnt);
`endif
            end

            // Effect of the coming edge.
            acc = e_valid && !s && !d;
            if (r) begin
                m_last = RST_PC; m_started = 1'b0; m_cnt = 32'd0; m_known = 1'b1;
            end else begin
                m_last = e_fetch; m_started = 1'b1;
                if (acc) m_cnt = m_cnt + 32'd1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
